// File: rtl/hpm_counter_bank_pkg.sv
// Shared core definitions: register selects and EVCFG bit positions
// used by the performance counter bank.
package p_hardisc;

   typedef logic [1:0] hpm_sel;

   localparam hpm_sel HPM_SEL_CNTLO   = 2'd0;
   localparam hpm_sel HPM_SEL_CNTHI   = 2'd1;
   localparam hpm_sel HPM_SEL_EVCFG   = 2'd2;
   localparam hpm_sel HPM_SEL_INHIBIT = 2'd3;

   localparam int HPM_EVCFG_OVF = 30;
   localparam int HPM_EVCFG_IEN = 31;

endpackage

// File: rtl/hpm_counter_bank_if.sv
// Indexed register port between the CSR unit (master) and the counter bank (slave).
interface hpm_counter_bank_if #(
   parameter int IDX_W = 2
);
   import p_hardisc::*;

   logic             s_csr_we_i;
   logic             s_csr_re_i;
   hpm_sel           s_csr_sel_i;
   logic [IDX_W-1:0] s_csr_idx_i;
   logic [31:0]      s_csr_wdata_i;
   logic [31:0]      s_csr_rdata_o;
   logic             s_csr_rvalid_o;

   modport master (
      output s_csr_we_i, s_csr_re_i, s_csr_sel_i, s_csr_idx_i, s_csr_wdata_i,
      input  s_csr_rdata_o, s_csr_rvalid_o
   );

   modport slave (
      input  s_csr_we_i, s_csr_re_i, s_csr_sel_i, s_csr_idx_i, s_csr_wdata_i,
      output s_csr_rdata_o, s_csr_rvalid_o
   );
endinterface

// File: rtl/hpm_counter_bank_slice.sv
// One performance counter: count register, event select, sticky overflow and irq enable.
// A CPU write to either counter half takes precedence over that cycle's increment.
module hpm_counter_slice
   import p_hardisc::*;
#(
   parameter int CNT_WIDTH = 64
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic        wr_cfg,
   input  logic [31:0] wdata,
   output logic [63:0] cnt,
   output logic [7:0]  evsel,
   output logic        ovf,
   output logic        irq_en
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 wrap;

   assign cnt = 64'(cnt_q);

   // NOTE: every output of this block is given a value before any branch, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (wr_lo) begin
         cnt_d = CNT_WIDTH'({cnt[63:32], wdata});
      end else if (wr_hi) begin
         cnt_d = CNT_WIDTH'({wdata, cnt[31:0]});
      end else if (inc) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
         wrap  = &cnt_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         // NOTE: the counter state is architecturally visible, so all of it is reset, not just control.
         cnt_q  <= '0;
         evsel  <= '0;
         ovf    <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_cfg) begin
            evsel  <= wdata[7:0];
            irq_en <= wdata[HPM_EVCFG_IEN];
         end
         // a fresh overflow wins over a same-cycle write-one-to-clear
         if (wrap) begin
            ovf <= 1'b1;
         end else if (wr_cfg && wdata[HPM_EVCFG_OVF]) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CNT performance counters with a global inhibit mask, event routing,
// registered 1-cycle register reads and a registered overflow interrupt.
module hpm_counter_bank
   import p_hardisc::*;
#(
   parameter int NUM_CNT   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int NUM_EVT   = 8,
   localparam int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
   input  logic               s_clk_i,
   input  logic               s_reset_i,
   input  logic [NUM_EVT-1:0] s_evt_i,
   hpm_counter_bank_if.slave  csr,
   output logic [NUM_CNT-1:0] s_ovf_o,
   output logic               s_ovf_irq_o
);

   logic [NUM_CNT-1:0] inhibit_q;
   logic [NUM_CNT-1:0] irq_en;
   logic [63:0]        cnt   [NUM_CNT];
   logic [7:0]         evsel [NUM_CNT];
   logic [255:0]       evt_pad;
   logic [31:0]        rd_val;

   // bit 0 and everything above NUM_EVT are zero, so evsel 0 or out of range never counts
   assign evt_pad = 256'({s_evt_i, 1'b0});

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
      logic hit;
      logic inc;

      assign hit = csr.s_csr_we_i && (csr.s_csr_idx_i == IDX_W'(i));
      assign inc = !inhibit_q[i] && evt_pad[evsel[i]];

      hpm_counter_slice #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_slice (
         .s_clk_i   (s_clk_i),
         .s_reset_i (s_reset_i),
         .inc       (inc),
         .wr_lo     (hit && csr.s_csr_sel_i == HPM_SEL_CNTLO),
         .wr_hi     (hit && csr.s_csr_sel_i == HPM_SEL_CNTHI),
         .wr_cfg    (hit && csr.s_csr_sel_i == HPM_SEL_EVCFG),
         .wdata     (csr.s_csr_wdata_i),
         .cnt       (cnt[i]),
         .evsel     (evsel[i]),
         .ovf       (s_ovf_o[i]),
         .irq_en    (irq_en[i])
      );
   end

   // indices with no counter match no loop iteration and read as zero
   always_comb begin
      rd_val = '0;
      if (csr.s_csr_sel_i == HPM_SEL_INHIBIT) begin
         rd_val = 32'(inhibit_q);
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (csr.s_csr_idx_i == IDX_W'(i)) begin
               case (csr.s_csr_sel_i)
                  HPM_SEL_CNTLO: rd_val = cnt[i][31:0];
                  HPM_SEL_CNTHI: rd_val = cnt[i][63:32];
                  default:       rd_val = {irq_en[i], s_ovf_o[i], 22'd0, evsel[i]};
               endcase
            end
         end
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         inhibit_q          <= '1;
         csr.s_csr_rdata_o  <= '0;
         csr.s_csr_rvalid_o <= 1'b0;
         s_ovf_irq_o        <= 1'b0;
      end else begin
         if (csr.s_csr_we_i && csr.s_csr_sel_i == HPM_SEL_INHIBIT) begin
            inhibit_q <= csr.s_csr_wdata_i[NUM_CNT-1:0];
         end
         csr.s_csr_rvalid_o <= csr.s_csr_re_i;
         if (csr.s_csr_re_i) begin
            csr.s_csr_rdata_o <= rd_val;
         end
         s_ovf_irq_o <= |(s_ovf_o & irq_en);
      end
   end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: a 4x64-bit bank tracked by a behavioural model,
// plus a 3x16-bit bank for narrow-width and unpopulated-index cases.
module tb_hpm_counter_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tgt = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [1:0]  sel = '0;
   logic [1:0]  idx = '0;
   logic [31:0] wdata = '0;
   logic [7:0]  evt_a = '0;
   logic [7:0]  evt_b = '0;
   logic [3:0]  ovf_a;
   logic [2:0]  ovf_b;
   logic        irq_a;
   logic        irq_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hpm_counter_bank_if #(.IDX_W(2)) bus_a ();
   hpm_counter_bank_if #(.IDX_W(2)) bus_b ();

   assign bus_a.s_csr_we_i    = we & ~tgt;
   assign bus_a.s_csr_re_i    = re & ~tgt;
   assign bus_a.s_csr_sel_i   = sel;
   assign bus_a.s_csr_idx_i   = idx;
   assign bus_a.s_csr_wdata_i = wdata;
   assign bus_b.s_csr_we_i    = we & tgt;
   assign bus_b.s_csr_re_i    = re & tgt;
   assign bus_b.s_csr_sel_i   = sel;
   assign bus_b.s_csr_idx_i   = idx;
   assign bus_b.s_csr_wdata_i = wdata;

   hpm_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(64), .NUM_EVT(8)) dut_a (
      .s_clk_i     (clk),
      .s_reset_i   (rst),
      .s_evt_i     (evt_a),
      .csr         (bus_a.slave),
      .s_ovf_o     (ovf_a),
      .s_ovf_irq_o (irq_a)
   );

   hpm_counter_bank #(.NUM_CNT(3), .CNT_WIDTH(16), .NUM_EVT(8)) dut_b (
      .s_clk_i     (clk),
      .s_reset_i   (rst),
      .s_evt_i     (evt_b),
      .csr         (bus_b.slave),
      .s_ovf_o     (ovf_b),
      .s_ovf_irq_o (irq_b)
   );

   // behavioural model of bank A
   logic [63:0] m_cnt [4];
   logic [7:0]  m_evsel [4];
   logic [3:0]  m_ovf, m_ien, m_inh;
   logic [31:0] last_rd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]   = '0;
         m_evsel[i] = '0;
      end
      m_ovf   = '0;
      m_ien   = '0;
      m_inh   = 4'hF;
      last_rd = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] s, input logic [1:0] i);
      case (s)
         2'd0:    return m_cnt[i][31:0];
         2'd1:    return m_cnt[i][63:32];
         2'd2:    return {m_ien[i], m_ovf[i], 22'd0, m_evsel[i]};
         default: return {28'd0, m_inh};
      endcase
   endfunction

   task automatic model_step();
      bit wr, inc, wrap;
      for (int i = 0; i < 4; i++) begin
         wr   = we && !tgt && (idx == 2'(i));
         inc  = 0;
         wrap = 0;
         if (!m_inh[i] && m_evsel[i] >= 1 && m_evsel[i] <= 8)
            inc = evt_a[int'(m_evsel[i]) - 1];
         if (wr && sel == 2'd0) begin
            m_cnt[i] = {m_cnt[i][63:32], wdata};
         end else if (wr && sel == 2'd1) begin
            m_cnt[i] = {wdata, m_cnt[i][31:0]};
         end else if (inc) begin
            wrap     = (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF);
            m_cnt[i] = m_cnt[i] + 64'd1;
         end
         if (wrap) m_ovf[i] = 1'b1;
         else if (wr && sel == 2'd2 && wdata[30]) m_ovf[i] = 1'b0;
         if (wr && sel == 2'd2) begin
            m_evsel[i] = wdata[7:0];
            m_ien[i]   = wdata[31];
         end
      end
      if (we && !tgt && sel == 2'd3) m_inh = wdata[3:0];
   endtask

   // one clock: predict, advance, then compare bank A outputs and bank B read handshake
   task automatic tick();
      logic [31:0] exp_rd;
      logic        exp_irq;
      logic        re_a, re_b;
      exp_rd  = model_read(sel, idx);
      exp_irq = |(m_ovf & m_ien);
      re_a    = re && !tgt;
      re_b    = re && tgt;
      @(posedge clk);
      model_step();
      #1;
      check("rvalid_a", bus_a.s_csr_rvalid_o, re_a);
      if (re_a) begin
         check("rdata_a", bus_a.s_csr_rdata_o, exp_rd);
         last_rd = exp_rd;
      end else begin
         check("rdata_hold_a", bus_a.s_csr_rdata_o, last_rd);
      end
      check("ovf_a", ovf_a, m_ovf);
      check("irq_a", irq_a, exp_irq);
      check("rvalid_b", bus_b.s_csr_rvalid_o, re_b);
   endtask

   task automatic op(input logic t, input logic w, input logic r, input logic [1:0] s,
                     input logic [1:0] i, input logic [31:0] d);
      tgt   = t;
      we    = w;
      re    = r;
      sel   = s;
      idx   = i;
      wdata = d;
      tick();
      we = 1'b0;
      re = 1'b0;
   endtask

   initial begin
      model_reset();
      // an access presented while reset is high must be discarded
      tgt   = 1'b0;
      we    = 1'b1;
      re    = 1'b1;
      sel   = 2'd3;
      wdata = '0;
      evt_a = '1;
      evt_b = '1;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      we    = 1'b0;
      re    = 1'b0;
      evt_a = '0;
      evt_b = '0;
      check("rst_rvalid_a", bus_a.s_csr_rvalid_o, 1'b0);
      check("rst_rdata_a", bus_a.s_csr_rdata_o, 32'd0);
      check("rst_ovf_a", ovf_a, 4'd0);
      check("rst_irq_a", irq_a, 1'b0);
      check("rst_rvalid_b", bus_b.s_csr_rvalid_o, 1'b0);
      check("rst_ovf_b", ovf_b, 3'd0);

      op(0, 0, 1, 2'd3, 2'd0, 0);
      check("inhibit_rst", bus_a.s_csr_rdata_o, 32'hF);
      op(0, 0, 1, 2'd0, 2'd0, 0);
      check("cnt0_rst", bus_a.s_csr_rdata_o, 32'd0);

      // counter 1 on event 3, ten pulses
      op(0, 1, 0, 2'd2, 2'd1, 32'd3);
      op(0, 1, 0, 2'd3, 2'd0, 32'd0);
      evt_a = 8'h04;
      repeat (10) tick();
      evt_a = 8'h00;
      op(0, 0, 1, 2'd0, 2'd1, 0);
      check("cnt1_ten", bus_a.s_csr_rdata_o, 32'd10);
      op(0, 0, 1, 2'd0, 2'd0, 0);
      check("cnt0_idle", bus_a.s_csr_rdata_o, 32'd0);

      // full 64-bit wrap with interrupt
      op(0, 1, 0, 2'd0, 2'd0, 32'hFFFF_FFFF);
      op(0, 1, 0, 2'd1, 2'd0, 32'hFFFF_FFFF);
      op(0, 1, 0, 2'd2, 2'd0, 32'h8000_0001);
      evt_a = 8'h01;
      tick();
      evt_a = 8'h00;
      check("wrap_ovf", ovf_a[0], 1'b1);
      check("irq_lag", irq_a, 1'b0);
      op(0, 0, 1, 2'd0, 2'd0, 0);
      check("wrap_cnt", bus_a.s_csr_rdata_o, 32'd0);
      check("irq_rise", irq_a, 1'b1);

      // W1C collides with a new wrap, then W1C alone
      op(0, 1, 0, 2'd0, 2'd0, 32'hFFFF_FFFF);
      op(0, 1, 0, 2'd1, 2'd0, 32'hFFFF_FFFF);
      evt_a = 8'h01;
      op(0, 1, 0, 2'd2, 2'd0, 32'hC000_0001);
      evt_a = 8'h00;
      check("w1c_vs_wrap", ovf_a[0], 1'b1);
      op(0, 1, 0, 2'd2, 2'd0, 32'hC000_0001);
      check("w1c_clear", ovf_a[0], 1'b0);
      tick();
      check("irq_drop", irq_a, 1'b0);

      // CPU write beats increment; read-during-write returns old value
      op(0, 1, 0, 2'd2, 2'd2, 32'd2);
      evt_a = 8'h02;
      op(0, 1, 0, 2'd0, 2'd2, 32'd5);
      evt_a = 8'h00;
      op(0, 0, 1, 2'd0, 2'd2, 0);
      check("wr_beats_inc", bus_a.s_csr_rdata_o, 32'd5);
      op(0, 1, 1, 2'd0, 2'd2, 32'd9);
      check("rw_old", bus_a.s_csr_rdata_o, 32'd5);
      op(0, 0, 1, 2'd0, 2'd2, 0);
      check("rw_new", bus_a.s_csr_rdata_o, 32'd9);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         tgt   = 1'b0;
         we    = ($urandom_range(0, 2) == 0);
         re    = $urandom_range(0, 1) == 1;
         sel   = 2'($urandom_range(0, 3));
         idx   = 2'($urandom_range(0, 3));
         wdata = $urandom;
         if (sel <= 2'd1 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFFF;
         if (sel == 2'd2) wdata[7:0] = 8'($urandom_range(0, 10));
         if (sel == 2'd3 && $urandom_range(0, 3) != 0) wdata[3:0] = 4'd0;
         evt_a = 8'($urandom);
         tick();
      end
      we    = 1'b0;
      re    = 1'b0;
      evt_a = 8'h00;

      // narrow 16-bit bank with three counters
      op(1, 1, 0, 2'd0, 2'd0, 32'h0000_FFFF);
      op(1, 1, 0, 2'd1, 2'd0, 32'hFFFF_FFFF);
      op(1, 1, 0, 2'd2, 2'd0, 32'd1);
      op(1, 1, 0, 2'd3, 2'd0, 32'd0);
      evt_b = 8'h01;
      tick();
      evt_b = 8'h00;
      check("b_wrap_ovf", ovf_b, 3'b001);
      op(1, 0, 1, 2'd0, 2'd0, 0);
      check("b_wrap_cnt", bus_b.s_csr_rdata_o, 32'd0);
      op(1, 0, 1, 2'd1, 2'd0, 0);
      check("b_hi_zero", bus_b.s_csr_rdata_o, 32'd0);
      op(1, 1, 0, 2'd0, 2'd1, 32'h0001_2345);
      op(1, 0, 1, 2'd0, 2'd1, 0);
      check("b_trunc", bus_b.s_csr_rdata_o, 32'h0000_2345);
      op(1, 1, 0, 2'd0, 2'd3, 32'd7);
      op(1, 0, 1, 2'd0, 2'd3, 0);
      check("b_idx_oob", bus_b.s_csr_rdata_o, 32'd0);
      op(1, 0, 1, 2'd3, 2'd0, 0);
      check("b_inhibit", bus_b.s_csr_rdata_o, 32'd0);
      check("b_irq_off", irq_b, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
